// File: rtl/x_dl_pkg.sv
// Shared types and helpers for the delay-line edge-capture controller.
package x_dl_pkg;
  localparam int TAPS_DEFAULT  = 128;
  localparam int POS_W_DEFAULT = 8;
  // Widest tap vector first_zero() accepts; narrower vectors are zero-extended.
  localparam int TAPS_MAX      = 1024;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LAUNCH, ST_CAPTURE, ST_ENCODE, ST_DONE, ST_DRAIN
  } state_e;

  // Index of the first zero among the low n bits of v; n when all are ones.
  function automatic int first_zero(input logic [TAPS_MAX-1:0] v, input int n);
    int r;
    r = n;
    for (int k = TAPS_MAX-1; k >= 0; k--)
      if (k < n && !v[k]) r = k;
    return r;
  endfunction
endpackage

// File: rtl/x_therm_encode.sv
// Combinational thermometer-to-position encoder over the captured tap vector.
// X_DL_BUBBLE_FILT_EN adds a 3-tap majority filter ahead of the scan.
module x_therm_encode
  import x_dl_pkg::*;
#(
  parameter int TAPS  = TAPS_DEFAULT,
  parameter int POS_W = POS_W_DEFAULT
) (
  input  logic [TAPS-1:0]  i_taps,
  output logic [POS_W-1:0] o_pos,
  output logic             o_ovf
);
  logic [TAPS-1:0] taps;
  int              fz;

`ifdef X_DL_BUBBLE_FILT_EN
  // End taps have only one neighbour, so they pass through unfiltered.
  always_comb begin
    taps = i_taps;
    for (int k = 1; k < TAPS-1; k++)
      taps[k] = (i_taps[k-1] & i_taps[k]) | (i_taps[k] & i_taps[k+1]) |
                (i_taps[k-1] & i_taps[k+1]);
  end
`else
  assign taps = i_taps;
`endif

  always_comb begin
    fz    = first_zero(TAPS_MAX'(taps), TAPS);
    o_pos = POS_W'(fz);
    o_ovf = (fz == TAPS);
  end
endmodule

// File: rtl/x_dl_edge_capture.sv
// Launches an edge into the delay line, captures and encodes the taps, and
// keeps min/max/count statistics. Optional macro: X_DL_BUBBLE_FILT_EN.
module x_dl_edge_capture
  import x_dl_pkg::*;
#(
  parameter int TAPS   = TAPS_DEFAULT,
  parameter int POS_W  = POS_W_DEFAULT,
  parameter int SETTLE = 1,
  parameter int CLEAR  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_clr_stats,
  input  logic [TAPS-1:0]  i_dl,
  output logic             o_launch,
  output logic             o_busy,
  output logic             o_valid,
  output logic [POS_W-1:0] o_pos,
  output logic             o_ovf,
  output logic [POS_W-1:0] o_min,
  output logic [POS_W-1:0] o_max,
  output logic [15:0]      o_count
);
  localparam int CNT_MAX = (SETTLE > CLEAR) ? SETTLE : CLEAR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             launch_q, launch_d, busy_q, busy_d, valid_q, valid_d;
  logic [TAPS-1:0]  cap_q, cap_d;
  logic [POS_W-1:0] enc_pos_q, enc_pos_d, pos_q, pos_d;
  logic             enc_ovf_q, enc_ovf_d, ovf_q, ovf_d;
  logic [POS_W-1:0] min_q, min_d, max_q, max_d;
  logic [15:0]      stat_cnt_q, stat_cnt_d;
  logic [POS_W-1:0] scan_pos;
  logic             scan_ovf;

  x_therm_encode #(.TAPS(TAPS), .POS_W(POS_W)) u_enc (
    .i_taps(cap_q), .o_pos(scan_pos), .o_ovf(scan_ovf)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    launch_d  = launch_q;
    valid_d   = 1'b0;
    cap_d     = cap_q;
    enc_pos_d = enc_pos_q;
    enc_ovf_d = enc_ovf_q;
    pos_d     = pos_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d  = ST_LAUNCH;
        launch_d = 1'b1;
        cnt_d    = CNT_W'(SETTLE - 1);
      end
      ST_LAUNCH: if (cnt_q == '0) begin
        cap_d   = i_dl;
        state_d = ST_CAPTURE;
      end else cnt_d = cnt_q - CNT_W'(1);
      ST_CAPTURE: begin
        enc_pos_d = scan_pos;
        enc_ovf_d = scan_ovf;
        state_d   = ST_ENCODE;
      end
      ST_ENCODE: begin
        pos_d   = enc_pos_q;
        ovf_d   = enc_ovf_q;
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        launch_d = 1'b0;
        cnt_d    = CNT_W'(CLEAR - 1);
        state_d  = ST_DRAIN;
      end
      ST_DRAIN: if (cnt_q == '0) state_d = ST_IDLE;
                else cnt_d = cnt_q - CNT_W'(1);
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Statistics fold in the sample at the end of the o_valid cycle, after any clear.
  always_comb begin
    min_d      = i_clr_stats ? '1    : min_q;
    max_d      = i_clr_stats ? '0    : max_q;
    stat_cnt_d = i_clr_stats ? 16'd0 : stat_cnt_q;
    if (valid_q) begin
      if (pos_q < min_d) min_d = pos_q;
      if (pos_q > max_d) max_d = pos_q;
      if (stat_cnt_d != 16'hFFFF) stat_cnt_d = stat_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      launch_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      cap_q      <= '0;
      enc_pos_q  <= '0;
      enc_ovf_q  <= 1'b0;
      pos_q      <= '0;
      ovf_q      <= 1'b0;
      min_q      <= '1;
      max_q      <= '0;
      stat_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      launch_q   <= launch_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      cap_q      <= cap_d;
      enc_pos_q  <= enc_pos_d;
      enc_ovf_q  <= enc_ovf_d;
      pos_q      <= pos_d;
      ovf_q      <= ovf_d;
      min_q      <= min_d;
      max_q      <= max_d;
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign o_launch = launch_q;
  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_pos    = pos_q;
  assign o_ovf    = ovf_q;
  assign o_min    = min_q;
  assign o_max    = max_q;
  assign o_count  = stat_cnt_q;
endmodule

// File: tb/tb_x_dl_edge_capture.sv
// Bench for x_dl_edge_capture: phase-based reference model checked every cycle,
// plus directed runs with hand-computed results.
module tb_x_dl_edge_capture;
  localparam int SETTLE = 1;
  localparam int CLEAR  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic [127:0] dl = '0;
  logic         o_launch, o_busy, o_valid, o_ovf;
  logic [7:0]   o_pos, o_min, o_max;
  logic [15:0]  o_count;

  int checks = 0;
  int failures = 0;

  x_dl_edge_capture #(.TAPS(128), .POS_W(8), .SETTLE(SETTLE), .CLEAR(CLEAR)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clr_stats(clr), .i_dl(dl),
    .o_launch(o_launch), .o_busy(o_busy), .o_valid(o_valid), .o_pos(o_pos),
    .o_ovf(o_ovf), .o_min(o_min), .o_max(o_max), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Position = run of ones from tap 0, after optional majority smoothing.
  function automatic int mdl_pos(input logic [127:0] v);
    logic [127:0] f;
    int n;
    f = v;
`ifdef X_DL_BUBBLE_FILT_EN
    for (int k = 1; k < 127; k++)
      f[k] = (int'(v[k-1]) + int'(v[k]) + int'(v[k+1])) >= 2;
`endif
    n = 0;
    while (n < 128 && f[n]) n++;
    return n;
  endfunction

  // Reference model: a run is described only by the edge it started on.
  int           cyc = 0, m_s = 0;
  bit           m_act = 0, m_ovf = 0;
  int           m_pos = 0, m_min = 255, m_max = 0, m_cnt = 0;
  logic [127:0] m_cap = '0;

  initial forever begin
    int p;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_act = 0; m_pos = 0; m_ovf = 0; m_min = 255; m_max = 0; m_cnt = 0;
    end else begin
      if (clr) begin m_min = 255; m_max = 0; m_cnt = 0; end
      if (m_act) begin
        p = cyc - m_s;
        if (p == SETTLE) m_cap = dl;
        if (p == SETTLE + 2) begin m_pos = mdl_pos(m_cap); m_ovf = (m_pos == 128); end
        if (p == SETTLE + 3) begin
          if (m_pos < m_min) m_min = m_pos;
          if (m_pos > m_max) m_max = m_pos;
          if (m_cnt < 65535) m_cnt++;
        end
        if (p == SETTLE + 3 + CLEAR) m_act = 0;
      end else if (start) begin
        m_act = 1; m_s = cyc;
      end
    end
  end

  int n_launch_cyc = 0, n_launch_rise = 0, n_valid = 0;
  initial begin
    logic prev_launch;
    int p;
    prev_launch = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      p = cyc - m_s;
      chk("launch", o_launch, m_act && p <= SETTLE + 2);
      chk("busy",   o_busy,   m_act && p <= SETTLE + 2 + CLEAR);
      chk("valid",  o_valid,  m_act && p == SETTLE + 2);
      chk("pos",    o_pos,    m_pos);
      chk("ovf",    o_ovf,    m_ovf);
      chk("min",    o_min,    m_min);
      chk("max",    o_max,    m_max);
      chk("count",  o_count,  m_cnt);
      if (o_launch) n_launch_cyc++;
      if (o_launch && !prev_launch) n_launch_rise++;
      if (o_valid) n_valid++;
      prev_launch = o_launch;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      step();
      if (!o_busy) return;
    end
    checks++; failures++;
    $display("FAIL wait_idle busy stuck t=%0t", $time);
  endtask

  task automatic run(input logic [127:0] v);
    dl = v; start = 1'b1; step(); start = 1'b0; wait_idle();
  endtask

  initial begin
    logic [127:0] one;
    int l0, r0, v0;
    one = 128'd1;
    repeat (3) step();
    chk("rst_launch", o_launch, 0);
    chk("rst_min", o_min, 8'hFF);
    chk("rst_count", o_count, 0);
    rst = 1'b1;
    step();

    l0 = n_launch_cyc; v0 = n_valid;
    run(128'h0000_0000_0000_0000_0000_0000_0000_FFFF);
    chk("r1_launch_cycles", n_launch_cyc - l0, SETTLE + 3);
    chk("r1_valids", n_valid - v0, 1);
    chk("r1_pos", o_pos, 16);
    chk("r1_ovf", o_ovf, 0);
    chk("r1_min", o_min, 16);
    chk("r1_max", o_max, 16);
    chk("r1_count", o_count, 1);

    clr = 1'b1; step(); clr = 1'b0;
    run('1);
    chk("ones_pos", o_pos, 128);
    chk("ones_ovf", o_ovf, 1);
    run('0);
    chk("zero_pos", o_pos, 0);
    chk("zero_ovf", o_ovf, 0);
    chk("zero_min", o_min, 0);
    chk("zero_max", o_max, 128);
    chk("zero_count", o_count, 2);

    run(128'h0000_0000_0000_0000_0000_0000_0000_FBFF);
`ifdef X_DL_BUBBLE_FILT_EN
    chk("bubble_pos", o_pos, 16);
`else
    chk("bubble_pos", o_pos, 10);
`endif

    // Held start: runs begin on every 9th edge, 12 of them in 100 edges.
    r0 = n_launch_rise; v0 = n_valid;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dl = (one << $urandom_range(0, 128)) - one;
      step();
    end
    start = 1'b0;
    wait_idle();
    chk("held_launches", n_launch_rise - r0, 12);
    chk("held_valids", n_valid - v0, 12);

    // Start pulses while busy are dropped.
    v0 = n_valid;
    dl = 128'hFF;
    start = 1'b1; step(); start = 1'b0; step();
    start = 1'b1; step(); start = 1'b0; step(); step();
    start = 1'b1; step(); start = 1'b0;
    wait_idle();
    chk("busy_pulse_valids", n_valid - v0, 1);
    chk("busy_pulse_pos", o_pos, 8);

    // Clear coincident with the o_valid cycle of a pos=40 sample.
    dl = (one << 40) - one;
    start = 1'b1; step(); start = 1'b0;
    repeat (SETTLE + 2) step();
    chk("clr_on_valid", o_valid, 1);
    clr = 1'b1; step(); clr = 1'b0;
    wait_idle();
    chk("clr_min", o_min, 40);
    chk("clr_max", o_max, 40);
    chk("clr_count", o_count, 1);

    // Count saturation from a preloaded value.
    force dut.stat_cnt_q = 16'hFFFE;
    m_cnt = 65534;
    step();
    release dut.stat_cnt_q;
    step();
    chk("preload_count", o_count, 16'hFFFE);
    run(128'h3); run(128'h7); run(128'hF);
    chk("sat_count", o_count, 16'hFFFF);

    // Reset during LAUNCH.
    dl = 128'hFFFF;
    start = 1'b1; step(); start = 1'b0;
    rst = 1'b0; step(); rst = 1'b1;
    chk("rstL_launch", o_launch, 0);
    chk("rstL_busy", o_busy, 0);
    chk("rstL_count", o_count, 0);
    chk("rstL_min", o_min, 8'hFF);
    repeat (6) step();

    // Reset during DRAIN, after a sample has been counted.
    start = 1'b1; step(); start = 1'b0;
    repeat (SETTLE + 4) step();
    chk("pre_rstD_count", o_count, 1);
    rst = 1'b0; step(); rst = 1'b1;
    chk("rstD_launch", o_launch, 0);
    chk("rstD_busy", o_busy, 0);
    chk("rstD_count", o_count, 0);
    chk("rstD_max", o_max, 0);
    chk("rstD_pos", o_pos, 0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
